// File: rtl/mlp_pkg.sv
// Shared constants and the requantize helper for the MLP accelerator.
// The controller uses the same package for its counter limits.
package mlp_pkg;

    localparam int DataW     = 8;
    localparam int AccW      = 20;
    localparam int WAddrW    = 11;
    localparam int XAddrW    = 8;
    localparam int NumLayers = 8;
    localparam int Dim       = 16;

    localparam int WDepth = NumLayers * Dim * Dim;
    localparam int XDepth = Dim * Dim;

    typedef logic signed [AccW-1:0] acc_t;
    typedef logic signed [2*DataW-1:0] prod_t;

    localparam acc_t SatMax = 20'sd127;
    localparam acc_t SatMin = -20'sd128;

    // Arithmetic shift, saturate to int8, then optionally clamp negatives to zero.
    function automatic logic [DataW-1:0] requant(input acc_t acc, input int shift, input bit relu);
        acc_t             r;
        logic [DataW-1:0] q;
        r = acc >>> shift;
        if (r > SatMax) begin
            q = 8'h7F;
        end else if (r < SatMin) begin
            q = 8'h80;
        end else begin
            q = r[DataW-1:0];
        end
        if (relu && r[AccW-1]) begin
            q = '0;
        end
        return q;
    endfunction

endpackage

// File: rtl/mlp_sram.sv
// Single-port synchronous memory: read-first, registered read data that holds
// when not enabled. Only the read register is reset, never the array.
module mlp_sram
    import mlp_pkg::*;
#(
    parameter int Depth = 256,
    parameter int Width = 8,
    localparam int AddrW = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             ren_i,
    input  logic             wen_i,
    input  logic [AddrW-1:0] addr_i,
    input  logic [Width-1:0] wdata_i,
    output logic [Width-1:0] rdata_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] rdata_q;
    logic [Width-1:0] rdata_d;

    always_ff @(posedge clk_i) begin
        if (wen_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Reading mem_q before the non-blocking write lands gives read-first behaviour.
    always_comb begin
        rdata_d = rdata_q;
        if (ren_i) begin
            rdata_d = mem_q[addr_i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mlp_datapath.sv
// MLP datapath: weight SRAM, ping-pong activation banks, signed MAC and the
// requantize/ReLU write-back. Pure executor of the controller's strobes.
module mlp_datapath
    import mlp_pkg::*;
#(
    parameter int Shift = 7,
    parameter bit Relu  = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [DataW-1:0]  load_data_i,
    input  logic              w_ren_i,
    input  logic              w_wen_i,
    input  logic [WAddrW-1:0] w_addr_i,
    input  logic              x_ren_i,
    input  logic              x_wen_i,
    input  logic              x_sel_i,
    input  logic [XAddrW-1:0] x_addr_i,
    input  logic              partial_sum_store_i,
    input  logic              x_sram_write_back_i,
    output logic [DataW-1:0]  result_data_o
);

    logic [DataW-1:0] w_rdata;
    logic [DataW-1:0] x0_rdata;
    logic [DataW-1:0] x1_rdata;
    logic [DataW-1:0] x_rdata;
    logic [DataW-1:0] x_wdata;
    logic             x_wbank;
    logic             x_rsel_q;
    logic             x_rsel_d;
    acc_t             acc_q;
    acc_t             acc_d;
    prod_t            prod;

    mlp_sram #(.Depth(WDepth), .Width(DataW)) u_w_sram (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .ren_i   (w_ren_i),
        .wen_i   (w_wen_i),
        .addr_i  (w_addr_i),
        .wdata_i (load_data_i),
        .rdata_o (w_rdata)
    );

    // Writing the bank opposite the read bank on write-back gives the layer ping-pong;
    // a plain load lands in the bank named by x_sel_i.
    assign x_wbank = x_sel_i ^ x_sram_write_back_i;
    assign x_wdata = x_sram_write_back_i ? requant(acc_q, Shift, Relu) : load_data_i;

    mlp_sram #(.Depth(XDepth), .Width(DataW)) u_x0_sram (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .ren_i   (x_ren_i & ~x_sel_i),
        .wen_i   (x_wen_i & ~x_wbank),
        .addr_i  (x_addr_i),
        .wdata_i (x_wdata),
        .rdata_o (x0_rdata)
    );

    mlp_sram #(.Depth(XDepth), .Width(DataW)) u_x1_sram (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .ren_i   (x_ren_i & x_sel_i),
        .wen_i   (x_wen_i & x_wbank),
        .addr_i  (x_addr_i),
        .wdata_i (x_wdata),
        .rdata_o (x1_rdata)
    );

    // Remember which bank the last read came from so the output tracks it.
    always_comb begin
        x_rsel_d = x_rsel_q;
        if (x_ren_i) begin
            x_rsel_d = x_sel_i;
        end
    end

    assign x_rdata = x_rsel_q ? x1_rdata : x0_rdata;
    assign prod    = $signed(w_rdata) * $signed(x_rdata);

    always_comb begin
        acc_d = acc_q;
        if (x_wen_i) begin
            acc_d = '0;
        end else if (partial_sum_store_i) begin
            acc_d = acc_q + {{(AccW-2*DataW){prod[2*DataW-1]}}, prod};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            acc_q    <= '0;
            x_rsel_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            x_rsel_q <= x_rsel_d;
        end
    end

    assign result_data_o = x_rdata;

endmodule

// File: tb/tb_mlp_datapath.sv
// Directed bench for mlp_datapath: three instances share stimulus so the
// Shift/Relu variants can be compared against hand-computed values.
module tb_mlp_datapath;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  load_data;
    logic        w_ren, w_wen;
    logic [10:0] w_addr;
    logic        x_ren, x_wen, x_sel;
    logic [7:0]  x_addr;
    logic        pss, wb;
    logic [7:0]  res0, res7, res7n;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    // Shift 0, ReLU on
    mlp_datapath #(.Shift(0), .Relu(1'b1)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .load_data_i(load_data),
        .w_ren_i(w_ren), .w_wen_i(w_wen), .w_addr_i(w_addr),
        .x_ren_i(x_ren), .x_wen_i(x_wen), .x_sel_i(x_sel), .x_addr_i(x_addr),
        .partial_sum_store_i(pss), .x_sram_write_back_i(wb), .result_data_o(res0)
    );

    // Shift 7, ReLU on
    mlp_datapath #(.Shift(7), .Relu(1'b1)) dut7 (
        .clk_i(clk), .rst_ni(rst_n), .load_data_i(load_data),
        .w_ren_i(w_ren), .w_wen_i(w_wen), .w_addr_i(w_addr),
        .x_ren_i(x_ren), .x_wen_i(x_wen), .x_sel_i(x_sel), .x_addr_i(x_addr),
        .partial_sum_store_i(pss), .x_sram_write_back_i(wb), .result_data_o(res7)
    );

    // Shift 7, ReLU off
    mlp_datapath #(.Shift(7), .Relu(1'b0)) dut7n (
        .clk_i(clk), .rst_ni(rst_n), .load_data_i(load_data),
        .w_ren_i(w_ren), .w_wen_i(w_wen), .w_addr_i(w_addr),
        .x_ren_i(x_ren), .x_wen_i(x_wen), .x_sel_i(x_sel), .x_addr_i(x_addr),
        .partial_sum_store_i(pss), .x_sram_write_back_i(wb), .result_data_o(res7n)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        load_data = '0; w_ren = 0; w_wen = 0; w_addr = '0;
        x_ren = 0; x_wen = 0; x_sel = 0; x_addr = '0; pss = 0; wb = 0;
    endtask

    task automatic w_write(input logic [10:0] a, input logic [7:0] d);
        w_wen = 1; w_addr = a; load_data = d;
        tick(); idle();
    endtask

    task automatic w_read(input logic [10:0] a);
        w_ren = 1; w_addr = a;
        tick(); idle();
    endtask

    task automatic x_write(input logic sel, input logic [7:0] a, input logic [7:0] d);
        x_wen = 1; x_sel = sel; x_addr = a; load_data = d; wb = 0;
        tick(); idle();
    endtask

    task automatic x_read(input logic sel, input logic [7:0] a);
        x_ren = 1; x_sel = sel; x_addr = a;
        tick(); idle();
    endtask

    // n Rd/Acc pairs over layer 0, given row, k = 0..n-1, X address k
    task automatic mac(input int n, input logic [3:0] row, input logic sel);
        for (int k = 0; k < n; k++) begin
            w_ren = 1; w_addr = {3'd0, row, k[3:0]};
            x_ren = 1; x_sel = sel; x_addr = k[7:0];
            tick(); idle();
            pss = 1;
            tick(); idle();
        end
    endtask

    task automatic writeback(input logic sel, input logic [7:0] a);
        x_wen = 1; wb = 1; x_sel = sel; x_addr = a;
        tick(); idle();
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        tick(); tick();
        rst_n = 1;
        checks++; if (res0 !== 8'h00) begin fails++; $display("FAIL reset_res0: got %h want 00", res0); end
        checks++; if (res7n !== 8'h00) begin fails++; $display("FAIL reset_res7n: got %h want 00", res7n); end
        checks++; if (dut0.acc_q !== 20'sd0) begin fails++; $display("FAIL reset_acc: got %0d want 0", dut0.acc_q); end
        checks++; if (dut0.w_rdata !== 8'h00) begin fails++; $display("FAIL reset_wrdata: got %h want 00", dut0.w_rdata); end
    endtask

    task automatic test_weight_load();
        w_write(11'h000, 8'h7F);
        w_write(11'h7FF, 8'h80);
        w_read(11'h000);
        checks++; if (dut0.w_rdata !== 8'h7F) begin fails++; $display("FAIL w_read_000: got %h want 7f", dut0.w_rdata); end
        w_read(11'h7FF);
        checks++; if (dut0.w_rdata !== 8'h80) begin fails++; $display("FAIL w_read_7ff: got %h want 80", dut0.w_rdata); end
        tick();
        checks++; if (dut0.w_rdata !== 8'h80) begin fails++; $display("FAIL w_hold: got %h want 80", dut0.w_rdata); end
        // simultaneous read and write returns old contents
        w_ren = 1; w_wen = 1; w_addr = 11'h000; load_data = 8'h11;
        tick(); idle();
        checks++; if (dut0.w_rdata !== 8'h7F) begin fails++; $display("FAIL w_rw_old: got %h want 7f", dut0.w_rdata); end
        w_read(11'h000);
        checks++; if (dut0.w_rdata !== 8'h11) begin fails++; $display("FAIL w_rw_new: got %h want 11", dut0.w_rdata); end
    endtask

    task automatic test_single_mac();
        for (int k = 0; k < 16; k++) begin
            x_write(1'b0, k[7:0], 8'd2);
            w_write({3'd0, 4'd0, k[3:0]}, 8'd3);
        end
        mac(16, 4'd0, 1'b0);
        checks++; if (dut0.acc_q !== 20'sd96) begin fails++; $display("FAIL mac_acc: got %0d want 96", dut0.acc_q); end
        writeback(1'b0, 8'd5);
        checks++; if (dut0.acc_q !== 20'sd0) begin fails++; $display("FAIL mac_clear: got %0d want 0", dut0.acc_q); end
        x_read(1'b1, 8'd5);
        checks++; if (res0 !== 8'd96) begin fails++; $display("FAIL mac_x1_shift0: got %0d want 96", res0); end
        checks++; if (res7 !== 8'd0) begin fails++; $display("FAIL mac_x1_shift7: got %0d want 0", res7); end
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 16; k++) begin
            x_write(1'b0, k[7:0], 8'h7F);
            w_write({3'd0, 4'd1, k[3:0]}, 8'h7F);
        end
        mac(16, 4'd1, 1'b0);
        checks++; if (dut7.acc_q !== 20'sd258064) begin fails++; $display("FAIL sat_acc_pos: got %0d want 258064", dut7.acc_q); end
        writeback(1'b0, 8'd6);
        for (int k = 0; k < 16; k++) x_write(1'b0, k[7:0], 8'h80);
        mac(16, 4'd1, 1'b0);
        checks++; if (dut7.acc_q !== -20'sd260096) begin fails++; $display("FAIL sat_acc_neg: got %0d want -260096", dut7.acc_q); end
        writeback(1'b0, 8'd7);
        x_read(1'b1, 8'd6);
        checks++; if (res7 !== 8'h7F) begin fails++; $display("FAIL sat_pos_relu: got %h want 7f", res7); end
        checks++; if (res7n !== 8'h7F) begin fails++; $display("FAIL sat_pos_norelu: got %h want 7f", res7n); end
        checks++; if (res0 !== 8'h7F) begin fails++; $display("FAIL sat_pos_shift0: got %h want 7f", res0); end
        x_read(1'b1, 8'd7);
        checks++; if (res7 !== 8'h00) begin fails++; $display("FAIL sat_neg_relu: got %h want 00", res7); end
        checks++; if (res7n !== 8'h80) begin fails++; $display("FAIL sat_neg_norelu: got %h want 80", res7n); end
    endtask

    task automatic test_ping_pong();
        x_write(1'b1, 8'd200, 8'h55);
        x_write(1'b1, 8'd201, 8'h66);
        x_write(1'b0, 8'd0, 8'd2);
        w_write({3'd0, 4'd3, 4'd0}, 8'd3);
        mac(1, 4'd3, 1'b0);
        writeback(1'b1, 8'd200);
        x_write(1'b0, 8'd201, 8'h33);
        x_read(1'b0, 8'd200);
        checks++; if (res0 !== 8'd6) begin fails++; $display("FAIL pp_wb_x0: got %h want 06", res0); end
        x_read(1'b0, 8'd201);
        checks++; if (res0 !== 8'h33) begin fails++; $display("FAIL pp_load_x0: got %h want 33", res0); end
        x_read(1'b1, 8'd200);
        checks++; if (res0 !== 8'h55) begin fails++; $display("FAIL pp_x1_200: got %h want 55", res0); end
        x_read(1'b1, 8'd201);
        checks++; if (res0 !== 8'h66) begin fails++; $display("FAIL pp_x1_201: got %h want 66", res0); end
    endtask

    task automatic test_result_stream();
        for (int i = 0; i < 256; i++) x_write(1'b0, i[7:0], i[7:0]);
        // same-bank read and write on one address returns the old byte
        x_ren = 1; x_wen = 1; x_sel = 0; x_addr = 8'd10; load_data = 8'hAA;
        tick(); idle();
        checks++; if (res0 !== 8'd10) begin fails++; $display("FAIL read_first: got %h want 0a", res0); end
        x_write(1'b0, 8'd10, 8'd10);
        for (int i = 0; i < 256; i++) begin
            x_ren = 1; x_sel = 0; x_addr = i[7:0];
            tick();
            checks++;
            if (res0 !== i[7:0]) begin fails++; $display("FAIL stream[%0d]: got %0d want %0d", i, res0, i); end
        end
        idle();
        tick();
        checks++; if (res0 !== 8'd255) begin fails++; $display("FAIL stream_hold: got %0d want 255", res0); end
    endtask

    task automatic test_reset_mid();
        // X0[k] = k now, W row 1 = 127: 127 * (0+1+2+3+4) = 1270
        mac(5, 4'd1, 1'b0);
        checks++; if (dut0.acc_q !== 20'sd1270) begin fails++; $display("FAIL mid_acc: got %0d want 1270", dut0.acc_q); end
        rst_n = 0;
        tick();
        rst_n = 1;
        checks++; if (dut0.acc_q !== 20'sd0) begin fails++; $display("FAIL mid_acc_rst: got %0d want 0", dut0.acc_q); end
        checks++; if (res0 !== 8'h00) begin fails++; $display("FAIL mid_res_rst: got %h want 00", res0); end
        checks++; if (dut0.w_rdata !== 8'h00) begin fails++; $display("FAIL mid_wrdata_rst: got %h want 00", dut0.w_rdata); end
        x_read(1'b0, 8'd77);
        checks++; if (res0 !== 8'd77) begin fails++; $display("FAIL mid_x0_keep: got %0d want 77", res0); end
        x_read(1'b1, 8'd5);
        checks++; if (res0 !== 8'd96) begin fails++; $display("FAIL mid_x1_keep: got %0d want 96", res0); end
        w_read({3'd0, 4'd1, 4'd0});
        checks++; if (dut0.w_rdata !== 8'h7F) begin fails++; $display("FAIL mid_w_keep: got %h want 7f", dut0.w_rdata); end
    endtask

    initial begin
        idle();
        rst_n = 0;
        test_reset();
        test_weight_load();
        test_single_mac();
        test_saturation();
        test_ping_pong();
        test_result_stream();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/mlp_datapath.md
# mlp_datapath

Arithmetic and storage datapath of the MLP accelerator, driven cycle-by-cycle by the `mlp_fsm` control outputs. It holds:
- the weight SRAM (8 layers × 16×16 int8);
- two ping-pong activation banks (256 × int8 each);
- a signed multiply-accumulate register;
- the requantize/ReLU stage that writes each layer's outputs back.

It contains no state machine of its own. It executes the enables, addresses and selects it receives, and returns final results on `result_data_o`.

## Interface
Parameters:
- `Shift`, 7: arithmetic right shift applied to the accumulator before saturation.
- `Relu`, 1: 1 = clamp negative requantized values to 0 on write-back; 0 = signed saturation only.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset. Synchronous, active-low; one clock, all flops on the rising edge.
- `load_data_i` in 8: payload byte. Weight write data during init; activation write data during load.
- `w_ren_i` in 1: weight SRAM read enable.
- `w_wen_i` in 1: weight SRAM write enable.
- `w_addr_i` in 11: weight address, formed as {layer[2:0], row[3:0], k[3:0]}.
- `x_ren_i` in 1: activation read enable.
- `x_wen_i` in 1: activation write enable.
- `x_sel_i` in 1: source bank for reads. Also the base for the write-bank rule below.
- `x_addr_i` in 8: activation address.
- `partial_sum_store_i` in 1: accumulate the product of the current read data.
- `x_sram_write_back_i` in 1: activation write source. 0 = `load_data_i`; 1 = requantized accumulator.
- `result_data_o` out 8: read data of the activation bank read on the previous cycle.

## Operation
- **Weight SRAM.** 2048×8, synchronous, 1-cycle read latency.
  - Write when `w_wen_i`: mem[w_addr_i] <= load_data_i.
  - Read when `w_ren_i`: w_rdata <= mem[w_addr_i].
  - w_rdata holds its value when `w_ren_i` = 0.
- **Activation banks.** X0 and X1, each 256×8, synchronous, 1-cycle read latency.
  - Read bank = `x_sel_i`.
  - Write bank = `x_sel_i` XOR `x_sram_write_back_i`. Consequences:
    - A load (wb=0, sel=0) writes X0.
    - Layer L reads X[L%2] and writes X[(L+1)%2].
    - After 8 layers the result sits in X0.
  - Read data is registered into x_rdata from the bank selected at the read cycle. x_rdata holds when `x_ren_i` = 0.
- **Accumulator.** acc, signed, 20 bits.
  - When `partial_sum_store_i`: acc <= acc + sext(w_rdata) × sext(x_rdata). Full 16-bit signed product.
  - When `x_wen_i` is high, acc <= 0 regardless of `x_sram_write_back_i`. This covers both write-back and load.
  - If `partial_sum_store_i` and `x_wen_i` are high together, the clear wins. The FSM never does this.
  - 20 bits holds 16 × (−128 × −128) = 262144 without overflow, so there is no overflow handling.
- **Requantize** (combinational, on write-back):
  - r = acc >>> Shift (arithmetic).
  - Saturate r to [−128, 127].
  - If Relu = 1 and r < 0, then r = 0.
  - The write-back value is the current acc, i.e. before the same-cycle clear.
- `result_data_o` = x_rdata, with no extra register.

## Timing
- **Reset values.** acc = 0, w_rdata = 0, x_rdata = 0, therefore `result_data_o` = 0. Memory contents are not reset and are undefined after power-up.
- **Reset mid-operation.** Clears acc and the read registers. Memory contents written before reset are preserved.
- **Read latency.** 1 cycle. A read asserted in cycle t is usable by `partial_sum_store_i` in cycle t+1; this is the FSM's Rd→Acc pairing.
- **Accumulate.** acc updates at the end of the Acc cycle. After the 16th Acc, the following Wb cycle writes requant(acc) and clears acc.
- **Result streaming.** Reads on cycles t, t+1, … produce `result_data_o` = X0[addr] on cycles t+1, t+2, …. This matches the controller's one-cycle-early read, which aligns data with result_valid.
- **Same-bank read and write, same cycle, same address.** Read-first: the read returns the old data.
- **Simultaneous `w_ren_i` and `w_wen_i`.** The write happens; the read returns the old data.

## Structure
- **`mlp_pkg`.** Holds the shared constants: DataW = 8, AccW = 20, WAddrW = 11, XAddrW = 8, NumLayers = 8, Dim = 16.
  - `mlp_fsm` uses the same package for its counter limits.
- **`mlp_sram #(Depth, Width)`.** Single-port synchronous memory with read-first behaviour, separate ren/wen, and no reset on the array.
  - Instantiated three times: W, X0, X1.
- **`mlp_datapath`.** Contains the bank-select logic, the accumulator, requantize and output muxing.

## Test plan
1. **Weight load/readback.**
   - Stimulus: write w_addr 0x000 = 0x7F and w_addr 0x7FF = 0x80, then read both.
   - Required response: w_rdata = 0x7F and 0x80, each one cycle after its read.
2. **Single-row MAC.**
   - Stimulus: X0[k] = 2 and W[k] = 3 for k = 0..15; 16 Rd/Acc pairs with sel = 0; then Wb at addr 5 with Shift = 0.
   - Required response: acc = 96 before Wb, 0 after Wb; X1[5] = 96.
3. **Saturation and ReLU.**
   - Stimulus: all products 127 × 127 with Shift = 7, then all products −128 × 127.
   - Required response: first write-back = 127 (saturated); second = 0 with Relu = 1, and = −128 (0x80) with Relu = 0.
4. **Ping-pong rule.**
   - Stimulus: sel = 1 with wb = 1 writes; then sel = 0 with wb = 0 writes.
   - Required response: the first lands in X0, the second in X0. Bank X1 is untouched in both cases (checked by readback).
5. **Result stream.**
   - Stimulus: X0[i] = i; read addresses 0..255 back-to-back.
   - Required response: `result_data_o` = 0, 1, …, 255 on consecutive cycles starting one cycle after the first read.
6. **Reset mid-accumulate.**
   - Stimulus: after 5 Acc cycles, pull rst_ni low for 1 cycle.
   - Required response: acc = 0 and `result_data_o` = 0; previously written W and X contents are still readable.
